// File: rtl/window_pointer_unit.sv
// Window pointer unit: owns CWP and WIM for the windowed register file, executes
// SAVE/RESTORE/RETT window moves, raises window traps and tracks trap nesting.
module window_pointer_unit #(
    parameter int NWINDOWS = 4,
    parameter int CWP_W    = 5
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                save,
    input  logic                restore,
    input  logic                rett,
    input  logic                trap_req,
    input  logic                wr_wim,
    input  logic [NWINDOWS-1:0] wim_data,
    input  logic                wr_cwp,
    input  logic [CWP_W-1:0]    cwp_data,
    output logic [CWP_W-1:0]    CWP,
    output logic [NWINDOWS-1:0] wim,
    output logic                trap,
    output logic [1:0]          tt,
    output logic                in_trap,
    output logic                error_mode,
    output logic                illegal_cwp
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_TRAP  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam int               IDX_W = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
    localparam logic [CWP_W-1:0] LAST  = CWP_W'(NWINDOWS - 1);

    localparam logic [1:0] TT_OVF = 2'd1;
    localparam logic [1:0] TT_UNF = 2'd2;
    localparam logic [1:0] TT_EXT = 2'd3;

    state_t              r_state;
    logic [CWP_W-1:0]    r_cwp;
    logic [NWINDOWS-1:0] r_wim;
    logic [1:0]          r_tt;
    logic                r_trap;
    logic                r_illegal;

    state_t              w_nextState;
    logic [CWP_W-1:0]    w_nextCwp;
    logic [NWINDOWS-1:0] w_nextWim;
    logic [1:0]          w_nextTt;
    logic                w_nextTrap;
    logic                w_nextIllegal;
    logic                w_raise;
    logic [1:0]          w_raiseTt;

    logic [CWP_W-1:0]    w_dec;
    logic [CWP_W-1:0]    w_inc;
    logic                w_wimDec;
    logic                w_wimInc;

    // Modulo-N neighbours of CWP; explicit wrap keeps non-power-of-two N correct
    assign w_dec    = (r_cwp == '0)   ? LAST : r_cwp - CWP_W'(1);
    assign w_inc    = (r_cwp == LAST) ? '0   : r_cwp + CWP_W'(1);
    assign w_wimDec = r_wim[w_dec[IDX_W-1:0]];
    assign w_wimInc = r_wim[w_inc[IDX_W-1:0]];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_RUN;
            r_cwp     <= '0;
            r_wim     <= '0;
            r_tt      <= '0;
            r_trap    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cwp     <= w_nextCwp;
            r_wim     <= w_nextWim;
            r_tt      <= w_nextTt;
            r_trap    <= w_nextTrap;
            r_illegal <= w_nextIllegal;
        end
    end

    // Only the highest-priority request acts; a trap condition while already in TRAP escalates to ERROR
    always_comb begin
        w_nextState   = r_state;
        w_nextCwp     = r_cwp;
        w_nextWim     = wr_wim ? wim_data : r_wim;
        w_nextTt      = r_tt;
        w_nextTrap    = 1'b0;
        w_nextIllegal = 1'b0;
        w_raise       = 1'b0;
        w_raiseTt     = 2'd0;

        case (r_state)
            S_ERROR: begin
                w_nextWim = r_wim;
            end
            default: begin
                if (trap_req) begin
                    w_raise   = 1'b1;
                    w_raiseTt = TT_EXT;
                end else if (rett) begin
                    if (r_state == S_RUN || w_wimInc) begin
                        w_nextState = S_ERROR;
                    end else begin
                        w_nextCwp   = w_inc;
                        w_nextState = S_RUN;
                    end
                end else if (restore) begin
                    if (w_wimInc) begin
                        w_raise   = 1'b1;
                        w_raiseTt = TT_UNF;
                    end else begin
                        w_nextCwp = w_inc;
                    end
                end else if (save) begin
                    if (w_wimDec) begin
                        w_raise   = 1'b1;
                        w_raiseTt = TT_OVF;
                    end else begin
                        w_nextCwp = w_dec;
                    end
                end else if (wr_cwp) begin
                    if (cwp_data <= LAST) begin
                        w_nextCwp = cwp_data;
                    end else begin
                        w_nextIllegal = 1'b1;
                    end
                end

                if (w_raise) begin
                    if (r_state == S_RUN) begin
                        w_nextCwp   = w_dec;
                        w_nextTrap  = 1'b1;
                        w_nextTt    = w_raiseTt;
                        w_nextState = S_TRAP;
                    end else begin
                        w_nextState = S_ERROR;
                    end
                end
            end
        endcase
    end

    assign CWP         = r_cwp;
    assign wim         = r_wim;
    assign trap        = r_trap;
    assign tt          = r_tt;
    assign in_trap     = (r_state == S_TRAP);
    assign error_mode  = (r_state == S_ERROR);
    assign illegal_cwp = r_illegal;

endmodule

// File: tb/tb_window_pointer_unit.sv
// Scoreboard bench for window_pointer_unit: directed vectors push hand-computed
// expected outputs; a monitor pops and compares one entry after every clock edge.
module tb_window_pointer_unit;

    logic       Clk;
    logic       Reset;
    logic       save;
    logic       restore;
    logic       rett;
    logic       trap_req;
    logic       wr_wim;
    logic [3:0] wim_data;
    logic       wr_cwp;
    logic [4:0] cwp_data;
    logic [4:0] CWP;
    logic [3:0] wim;
    logic       trap;
    logic [1:0] tt;
    logic       in_trap;
    logic       error_mode;
    logic       illegal_cwp;

    typedef struct packed {
        logic [4:0] cwp;
        logic [3:0] wim;
        logic       trap;
        logic [1:0] tt;
        logic       inTrap;
        logic       err;
        logic       ill;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    vectorCount = 0;
    int    missCount   = 0;

    window_pointer_unit #(.NWINDOWS(4), .CWP_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .save(save), .restore(restore), .rett(rett),
        .trap_req(trap_req), .wr_wim(wr_wim), .wim_data(wim_data),
        .wr_cwp(wr_cwp), .cwp_data(cwp_data), .CWP(CWP), .wim(wim), .trap(trap),
        .tt(tt), .in_trap(in_trap), .error_mode(error_mode), .illegal_cwp(illegal_cwp)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic exp_t mkExp(logic [4:0] c, logic [3:0] w, logic tp, logic [1:0] t,
                                   logic it, logic e, logic il);
        exp_t x;
        x.cwp = c; x.wim = w; x.trap = tp; x.tt = t; x.inTrap = it; x.err = e; x.ill = il;
        return x;
    endfunction

    // Drive one cycle of requests at the falling edge and queue what the next rising edge must produce
    task automatic applyStimulus(string name, logic rst, logic sv, logic rs, logic rt, logic tr,
                                 logic ww, logic [3:0] wd, logic wc, logic [4:0] cd, exp_t e);
        @(negedge Clk);
        Reset = rst; save = sv; restore = rs; rett = rt; trap_req = tr;
        wr_wim = ww; wim_data = wd; wr_cwp = wc; cwp_data = cd;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput();
        exp_t  e;
        exp_t  a;
        string n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        a = mkExp(CWP, wim, trap, tt, in_trap, error_mode, illegal_cwp);
        vectorCount++;
        if (a !== e) begin
            missCount++;
            $display("[TB] FAIL %s: got cwp=%0d wim=%b trap=%b tt=%0d in_trap=%b err=%b ill=%b, want cwp=%0d wim=%b trap=%b tt=%0d in_trap=%b err=%b ill=%b",
                     n, a.cwp, a.wim, a.trap, a.tt, a.inTrap, a.err, a.ill,
                     e.cwp, e.wim, e.trap, e.tt, e.inTrap, e.err, e.ill);
        end
    endtask

    // Monitor: every rising edge settles an output, so one queued entry is retired per cycle
    always @(posedge Clk) begin
        #1;
        if (expQ.size() > 0) checkOutput();
    end

    initial begin
        int waitCycles;
        Reset = 1'b1; save = 0; restore = 0; rett = 0; trap_req = 0;
        wr_wim = 0; wim_data = 4'h0; wr_cwp = 0; cwp_data = 5'd0;

        //            name           rst sv rs rt tr ww wd       wc cd      cwp wim     tp tt it er il
        applyStimulus("reset0",      1, 0, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("reset1",      1, 1, 1, 0, 1, 1, 4'hF,    1, 5'd2, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("save_wrap",   0, 1, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("save_2",      0, 1, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd2, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("save_1",      0, 1, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd1, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("wrcwp_3",     0, 0, 0, 0, 0, 0, 4'h0,    1, 5'd3, mkExp(5'd3, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("restore_wrap",0, 0, 1, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("save_oldwim", 0, 1, 0, 0, 0, 1, 4'b1000, 0, 5'd0, mkExp(5'd3, 4'b1000, 0, 2'd0, 0, 0, 0));
        applyStimulus("wrcwp_0",     0, 0, 0, 0, 0, 0, 4'h0,    1, 5'd0, mkExp(5'd0, 4'b1000, 0, 2'd0, 0, 0, 0));
        applyStimulus("ovf_trap",    0, 1, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b1000, 1, 2'd1, 1, 0, 0));
        applyStimulus("trap_pulse",  0, 0, 0, 0, 0, 1, 4'b0000, 0, 5'd0, mkExp(5'd3, 4'b0000, 0, 2'd1, 1, 0, 0));
        applyStimulus("rett_ok",     0, 0, 0, 1, 0, 1, 4'b0010, 0, 5'd0, mkExp(5'd0, 4'b0010, 0, 2'd1, 0, 0, 0));
        applyStimulus("unf_trap",    0, 0, 1, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b0010, 1, 2'd2, 1, 0, 0));
        applyStimulus("trap_restore",0, 0, 1, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd0, 4'b0010, 0, 2'd2, 1, 0, 0));
        applyStimulus("trap_save",   0, 1, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b0010, 0, 2'd2, 1, 0, 0));
        applyStimulus("rett_run",    0, 0, 0, 1, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd0, 4'b0010, 0, 2'd2, 0, 0, 0));
        applyStimulus("ext_trap",    0, 1, 1, 0, 1, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b0010, 1, 2'd3, 1, 0, 0));
        applyStimulus("nested_err",  0, 0, 0, 0, 1, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b0010, 0, 2'd3, 0, 1, 0));
        applyStimulus("err_save",    0, 1, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd3, 4'b0010, 0, 2'd3, 0, 1, 0));
        applyStimulus("err_wrcwp",   0, 0, 0, 0, 0, 1, 4'hF,    1, 5'd1, mkExp(5'd3, 4'b0010, 0, 2'd3, 0, 1, 0));
        applyStimulus("err_reset",   1, 0, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("illegal_cwp", 0, 0, 0, 0, 0, 0, 4'h0,    1, 5'd5, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 1));
        applyStimulus("ill_pulse",   0, 0, 0, 0, 0, 0, 4'h0,    1, 5'd4, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 1));
        applyStimulus("ill_clear",   0, 0, 0, 0, 0, 0, 4'h0,    1, 5'd1, mkExp(5'd1, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("restore_wins",0, 1, 1, 0, 0, 0, 4'h0,    1, 5'd0, mkExp(5'd2, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("rett_in_run", 0, 0, 0, 1, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd2, 4'b0000, 0, 2'd0, 0, 1, 0));
        applyStimulus("reset_wins",  1, 1, 0, 0, 1, 0, 4'h0,    0, 5'd0, mkExp(5'd0, 4'b0000, 0, 2'd0, 0, 0, 0));
        applyStimulus("trap_wr_ovr", 0, 0, 0, 0, 1, 0, 4'h0,    1, 5'd2, mkExp(5'd3, 4'b0000, 1, 2'd3, 1, 0, 0));
        applyStimulus("trap_rett_e", 0, 0, 0, 1, 0, 1, 4'b0001, 0, 5'd0, mkExp(5'd0, 4'b0001, 0, 2'd3, 0, 0, 0));
        applyStimulus("unf_wim0",    0, 0, 0, 0, 0, 0, 4'h0,    1, 5'd3, mkExp(5'd3, 4'b0001, 0, 2'd3, 0, 0, 0));
        applyStimulus("unf_at_last", 0, 0, 1, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd2, 4'b0001, 1, 2'd2, 1, 0, 0));
        applyStimulus("idle",        0, 0, 0, 0, 0, 0, 4'h0,    0, 5'd0, mkExp(5'd2, 4'b0001, 0, 2'd2, 1, 0, 0));

        @(negedge Clk);
        Reset = 0; save = 0; restore = 0; rett = 0; trap_req = 0; wr_wim = 0; wr_cwp = 0;
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(negedge Clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d entries left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
